// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit arbiter: FSM encoding,
// grant index width, timeout counter width and default timeout.
package uart_pkg;

   localparam int GRANT_W         = 2;
   localparam int CNT_W           = 16;
   localparam int TIMEOUT_DEFAULT = 65535;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_START     = 2'd1;
   localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
   localparam logic [1:0] ST_WAIT_DONE = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker. Priority starts one past the
// previous winner and wraps; the closest pending requester wins.
module rr_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 3
)(
   input  logic [NUM_REQ-1:0] req,
   input  logic [GRANT_W-1:0] last_grant,
   output logic [NUM_REQ-1:0] grant,
   output logic [GRANT_W-1:0] grant_idx
);

   int best_d;
   int d;

   // Pick the requester with the smallest wrap distance from last_grant+1.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      best_d    = NUM_REQ;
      d         = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         d = (i + NUM_REQ - 1 - int'(last_grant)) % NUM_REQ;
         if (req[i] && (d < best_d)) begin
            best_d    = d;
            grant     = '0;
            grant[i]  = 1'b1;
            grant_idx = GRANT_W'(i);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte sources. A byte is
// taken in IDLE, handed over with a tx_start/tx_clear_req handshake and
// the arbiter then tracks tx_busy until the frame is out. A watchdog
// aborts any transfer that stalls for TIMEOUT_CYC cycles.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ     = 3,
   parameter int DATA_W      = 8,
   parameter int TIMEOUT_CYC = TIMEOUT_DEFAULT
)(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [DATA_W-1:0]         tx_data,
   output logic                      tx_start,
   input  logic                      tx_clear_req,
   input  logic                      tx_busy,
   output logic [GRANT_W-1:0]        grant_id,
   output logic                      active,
   output logic                      timeout_err,
   input  logic                      err_clr
);

   logic [1:0]         state;
   logic [1:0]         state_nxt;
   logic [GRANT_W-1:0] last_grant;
   logic [GRANT_W-1:0] win_idx;
   logic [NUM_REQ-1:0] win;
   logic [DATA_W-1:0]  win_data;
   logic [CNT_W-1:0]   cnt;
   logic               accept;
   logic               expire;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req        (req_valid),
      .last_grant (last_grant),
      .grant      (win),
      .grant_idx  (win_idx)
   );

   // Acceptance only from IDLE; rst_n gates it so req_ready stays low in reset.
   assign accept    = (state == ST_IDLE) && rst_n && (|req_valid);
   assign req_ready = accept ? win : '0;
   assign active    = (state != ST_IDLE);

   // cnt counts completed busy cycles since acceptance; the abort fires on
   // the edge where the cycle count reaches TIMEOUT_CYC.
   assign expire = active &&
                   (({1'b0, cnt} + (CNT_W+1)'(1)) == (CNT_W+1)'(TIMEOUT_CYC));

   // Byte of the winning requester.
   always_comb begin
      win_data = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (win[i]) win_data = req_data[i*DATA_W +: DATA_W];
   end

   // Next-state logic; the watchdog abort overrides every handshake.
   always_comb begin
      state_nxt = state;
      if (expire) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:      if (accept)       state_nxt = ST_START;
            ST_START:     if (tx_clear_req) state_nxt = tx_busy ? ST_WAIT_DONE : ST_WAIT_BUSY;
            ST_WAIT_BUSY: if (tx_busy)      state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: if (!tx_busy)     state_nxt = ST_IDLE;
            default:                        state_nxt = ST_IDLE;
         endcase
      end
   end

   // State, registered tx_start, latched grant and saturating watchdog.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         tx_start   <= 1'b0;
         tx_data    <= '0;
         grant_id   <= '0;
         last_grant <= GRANT_W'(NUM_REQ-1);
         cnt        <= '0;
      end else begin
         state    <= state_nxt;
         tx_start <= (state_nxt == ST_START);
         if (accept) begin
            tx_data    <= win_data;
            grant_id   <= win_idx;
            last_grant <= win_idx;
            cnt        <= '0;
         end else if (active && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Sticky abort flag; a new abort wins over a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       timeout_err <= 1'b0;
      else if (expire)  timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (3 requesters, 8-bit bytes, 16-cycle timeout).
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  req_valid = '0;
   logic [23:0] req_data = '0;
   logic [2:0]  req_ready;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_clear_req = 1'b0;
   logic        tx_busy = 1'b0;
   logic [1:0]  grant_id;
   logic        active;
   logic        timeout_err;
   logic        err_clr = 1'b0;

   int vec  = 0;
   int errs = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NUM_REQ(3), .DATA_W(8), .TIMEOUT_CYC(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .tx_data      (tx_data),
      .tx_start     (tx_start),
      .tx_clear_req (tx_clear_req),
      .tx_busy      (tx_busy),
      .grant_id     (grant_id),
      .active       (active),
      .timeout_err  (timeout_err),
      .err_clr      (err_clr)
   );

   // Transmitter model: entered in START; clear, one busy cycle, then idle.
   task automatic xfer();
      @(negedge clk); tx_clear_req = 1'b1;
      @(negedge clk); tx_clear_req = 1'b0; tx_busy = 1'b1;
      @(negedge clk); tx_busy = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 3'b111;
      repeat (2) @(negedge clk);
      #1;
      vec++; if (req_ready !== 3'b000) begin errs++; $display("FAIL reset_ready got %b exp 000", req_ready); end
      vec++; if (tx_start !== 1'b0) begin errs++; $display("FAIL reset_tx_start got %b exp 0", tx_start); end
      vec++; if (tx_data !== 8'h00) begin errs++; $display("FAIL reset_tx_data got %h exp 00", tx_data); end
      vec++; if (grant_id !== 2'd0) begin errs++; $display("FAIL reset_grant_id got %0d exp 0", grant_id); end
      vec++; if (active !== 1'b0) begin errs++; $display("FAIL reset_active got %b exp 0", active); end
      vec++; if (timeout_err !== 1'b0) begin errs++; $display("FAIL reset_timeout_err got %b exp 0", timeout_err); end
      req_valid = 3'b000;
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_single();
      @(negedge clk); req_valid = 3'b010; req_data = 24'h00A500; #1;
      vec++; if (req_ready !== 3'b010) begin errs++; $display("FAIL single_ready got %b exp 010", req_ready); end
      @(posedge clk); #1;
      vec++; if (req_ready !== 3'b000) begin errs++; $display("FAIL single_ready_pulse got %b exp 000", req_ready); end
      vec++; if (tx_data !== 8'hA5) begin errs++; $display("FAIL single_tx_data got %h exp a5", tx_data); end
      vec++; if (grant_id !== 2'd1) begin errs++; $display("FAIL single_grant_id got %0d exp 1", grant_id); end
      vec++; if (tx_start !== 1'b1) begin errs++; $display("FAIL single_tx_start got %b exp 1", tx_start); end
      vec++; if (active !== 1'b1) begin errs++; $display("FAIL single_active got %b exp 1", active); end
      @(negedge clk); req_valid = 3'b000;
      @(posedge clk); #1;
      vec++; if (tx_start !== 1'b1) begin errs++; $display("FAIL single_start_held got %b exp 1", tx_start); end
      @(negedge clk); tx_clear_req = 1'b1;
      @(posedge clk); #1;
      vec++; if (tx_start !== 1'b0) begin errs++; $display("FAIL single_start_drop got %b exp 0", tx_start); end
      @(negedge clk); tx_clear_req = 1'b0; tx_busy = 1'b1;
      @(posedge clk); #1;
      vec++; if (active !== 1'b1) begin errs++; $display("FAIL single_active_busy got %b exp 1", active); end
      @(negedge clk); tx_busy = 1'b0;
      @(posedge clk); #1;
      vec++; if (active !== 1'b0) begin errs++; $display("FAIL single_active_done got %b exp 0", active); end
      vec++; if (tx_data !== 8'hA5) begin errs++; $display("FAIL single_data_hold got %h exp a5", tx_data); end
   endtask

   task automatic test_fairness();
      logic [2:0] exp_rdy;
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1; req_valid = 3'b111; req_data = 24'hC2C1C0;
      for (int k = 0; k < 6; k++) begin
         exp_rdy = 3'b001 << (k % 3);
         #1;
         vec++; if (req_ready !== exp_rdy) begin errs++; $display("FAIL fair_ready[%0d] got %b exp %b", k, req_ready, exp_rdy); end
         @(posedge clk); #1;
         vec++; if (grant_id !== 2'(k % 3)) begin errs++; $display("FAIL fair_grant[%0d] got %0d exp %0d", k, grant_id, k % 3); end
         vec++; if (tx_data !== 8'hC0 + 8'(k % 3)) begin errs++; $display("FAIL fair_data[%0d] got %h exp %h", k, tx_data, 8'hC0 + 8'(k % 3)); end
         xfer();
         @(negedge clk);
      end
      req_valid = 3'b000;
   endtask

   task automatic test_back_to_back();
      @(negedge clk); req_valid = 3'b001; req_data = 24'h000011; #1;
      vec++; if (req_ready !== 3'b001) begin errs++; $display("FAIL b2b_ready1 got %b exp 001", req_ready); end
      @(posedge clk); #1;
      vec++; if (tx_data !== 8'h11) begin errs++; $display("FAIL b2b_data1 got %h exp 11", tx_data); end
      req_data = 24'h000022;
      xfer();
      @(posedge clk); #1;
      vec++; if (tx_data !== 8'h11) begin errs++; $display("FAIL b2b_data_stable got %h exp 11", tx_data); end
      vec++; if (active !== 1'b0) begin errs++; $display("FAIL b2b_idle_gap got %b exp 0", active); end
      vec++; if (req_ready !== 3'b001) begin errs++; $display("FAIL b2b_ready2 got %b exp 001", req_ready); end
      @(posedge clk); #1;
      vec++; if (tx_data !== 8'h22) begin errs++; $display("FAIL b2b_data2 got %h exp 22", tx_data); end
      vec++; if (req_ready !== 3'b000) begin errs++; $display("FAIL b2b_ready2_pulse got %b exp 000", req_ready); end
      req_valid = 3'b000;
      xfer();
   endtask

   task automatic test_rr_skip_withdraw();
      // last winner is 0: search order 1,2,0 with 1 absent picks 2
      @(negedge clk); req_valid = 3'b101; req_data = 24'h330044; #1;
      vec++; if (req_ready !== 3'b100) begin errs++; $display("FAIL skip_ready got %b exp 100", req_ready); end
      @(posedge clk); #1;
      vec++; if (grant_id !== 2'd2) begin errs++; $display("FAIL skip_grant got %0d exp 2", grant_id); end
      vec++; if (tx_data !== 8'h33) begin errs++; $display("FAIL skip_data got %h exp 33", tx_data); end
      req_valid = 3'b011;
      xfer();
      req_valid = 3'b010;    // requester 0 withdraws before the next IDLE
      @(negedge clk); #1;
      vec++; if (req_ready !== 3'b010) begin errs++; $display("FAIL withdraw_ready got %b exp 010", req_ready); end
      @(posedge clk); #1;
      vec++; if (grant_id !== 2'd1) begin errs++; $display("FAIL withdraw_grant got %0d exp 1", grant_id); end
      vec++; if (timeout_err !== 1'b0) begin errs++; $display("FAIL withdraw_err got %b exp 0", timeout_err); end
      req_valid = 3'b000;
      xfer();
   endtask

   task automatic test_simul_clear_busy();
      @(negedge clk); req_valid = 3'b001; req_data = 24'h000055;
      @(posedge clk); #1; req_valid = 3'b000;
      @(negedge clk); tx_clear_req = 1'b1; tx_busy = 1'b1;
      @(posedge clk); #1;
      vec++; if (tx_start !== 1'b0) begin errs++; $display("FAIL simul_start got %b exp 0", tx_start); end
      @(negedge clk); tx_clear_req = 1'b0; tx_busy = 1'b0;
      @(posedge clk); #1;
      vec++; if (active !== 1'b0) begin errs++; $display("FAIL simul_direct_done got %b exp 0", active); end
   endtask

   task automatic test_timeout();
      @(negedge clk); req_valid = 3'b010; req_data = 24'h007700;
      @(posedge clk); #1; req_valid = 3'b000;
      vec++; if (tx_start !== 1'b1) begin errs++; $display("FAIL to_start got %b exp 1", tx_start); end
      for (int k = 1; k < 16; k++) begin
         @(posedge clk); #1;
         vec++; if (tx_start !== 1'b1) begin errs++; $display("FAIL to_hold[%0d] got %b exp 1", k, tx_start); end
      end
      @(posedge clk); #1;
      vec++; if (tx_start !== 1'b0) begin errs++; $display("FAIL to_drop got %b exp 0", tx_start); end
      vec++; if (timeout_err !== 1'b1) begin errs++; $display("FAIL to_err_set got %b exp 1", timeout_err); end
      vec++; if (active !== 1'b0) begin errs++; $display("FAIL to_idle got %b exp 0", active); end
      @(posedge clk); #1;
      vec++; if (timeout_err !== 1'b1) begin errs++; $display("FAIL to_err_sticky got %b exp 1", timeout_err); end
      @(negedge clk); err_clr = 1'b1;
      @(posedge clk); #1; err_clr = 1'b0;
      vec++; if (timeout_err !== 1'b0) begin errs++; $display("FAIL to_err_clr got %b exp 0", timeout_err); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk); req_valid = 3'b001; req_data = 24'h000066;
      @(posedge clk); #1; req_valid = 3'b000;
      @(negedge clk); tx_clear_req = 1'b1; tx_busy = 1'b1;
      @(negedge clk); req_valid = 3'b111; #1;
      vec++; if (active !== 1'b1) begin errs++; $display("FAIL rmid_pre_active got %b exp 1", active); end
      #1; rst_n = 1'b0; #1;
      vec++; if (active !== 1'b0) begin errs++; $display("FAIL rmid_active got %b exp 0", active); end
      vec++; if (tx_start !== 1'b0) begin errs++; $display("FAIL rmid_start got %b exp 0", tx_start); end
      vec++; if (tx_data !== 8'h00) begin errs++; $display("FAIL rmid_data got %h exp 00", tx_data); end
      vec++; if (grant_id !== 2'd0) begin errs++; $display("FAIL rmid_grant got %0d exp 0", grant_id); end
      vec++; if (req_ready !== 3'b000) begin errs++; $display("FAIL rmid_ready got %b exp 000", req_ready); end
      @(negedge clk); rst_n = 1'b1; tx_clear_req = 1'b0; tx_busy = 1'b0; #1;
      vec++; if (req_ready !== 3'b001) begin errs++; $display("FAIL rmid_first_ready got %b exp 001", req_ready); end
      @(posedge clk); #1;
      vec++; if (grant_id !== 2'd0) begin errs++; $display("FAIL rmid_first_grant got %0d exp 0", grant_id); end
      req_valid = 3'b000;
      xfer();
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_back_to_back();
      test_rr_skip_withdraw();
      test_simul_clear_busy();
      test_timeout();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
